// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer with an IDLE/RUN/PAUSED/EXPIRED control FSM,
// optional auto-reload on expiry and a registered one-cycle expiry pulse.
module bcd_countdown_timer #(
    parameter int NUM_DIGITS  = 2,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    reconfig,
    input  logic [4*NUM_DIGITS-1:0] set_value,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    timer_reset,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic                    running,
    output logic                    expired,
    output logic                    done_pulse,
    output logic                    zero
);

    localparam int W = 4 * NUM_DIGITS;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   reload_q, reload_d;
    logic           pulse_q, pulse_d;

    // Any nibble above 9 is not a legal BCD digit; saturate it to 9.
    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path infers a latch.
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        pulse_d  = 1'b0;
        if (reconfig) begin
            reload_d = clamp_bcd(set_value);
            count_d  = clamp_bcd(set_value);
            state_d  = IDLE;
        end else if (timer_reset) begin
            count_d = reload_q;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start && count_q != '0) state_d = RUN;
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (tick) begin
                        if (count_q == ONE) begin
                            pulse_d = 1'b1;
                            if (AUTO_RELOAD && reload_q != '0) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = EXPIRED;
                            end
                        end else begin
                            count_d = bcd_dec(count_q);
                        end
                    end
                end
                PAUSED:  if (start && !pause) state_d = RUN;
                EXPIRED: count_d = '0;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            pulse_q  <= pulse_d;
        end
    end

    assign digits_out = count_q;
    assign running    = (state_q == RUN);
    assign expired    = (state_q == EXPIRED);
    assign done_pulse = pulse_q;
    assign zero       = (count_q == '0);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench: three timer instances (2-digit, 3-digit, 2-digit auto-reload)
// compared every cycle against a decimal-arithmetic model, plus literal pins.
module tb_bcd_countdown_timer;

    localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSED = 2, ST_EXP = 3;

    typedef struct {
        int cnt;
        int rld;
        int st;
        bit pulse;
    } m_t;

    logic        clk = 1'b0;
    logic        rst_v[3], reconfig_v[3], tres_v[3], start_v[3], pause_v[3], tick_v[3];
    logic [31:0] set_v[3];
    logic [7:0]  dig0, dig2;
    logic [11:0] dig1;
    logic        running_v[3], expired_v[3], pulse_v[3], zero_v[3];

    m_t  mdl[3];
    int  nd[3] = '{2, 3, 2};
    bit  ar[3] = '{1'b0, 1'b0, 1'b1};
    bit  chk_en = 1'b0;
    int  total = 0;
    int  bad = 0;

    always #5 clk = ~clk;

    bcd_countdown_timer #(.NUM_DIGITS(2), .AUTO_RELOAD(1'b0)) u_d0 (
        .clk(clk), .rst(rst_v[0]), .tick(tick_v[0]), .reconfig(reconfig_v[0]),
        .set_value(set_v[0][7:0]), .start(start_v[0]), .pause(pause_v[0]),
        .timer_reset(tres_v[0]), .digits_out(dig0), .running(running_v[0]),
        .expired(expired_v[0]), .done_pulse(pulse_v[0]), .zero(zero_v[0]));

    bcd_countdown_timer #(.NUM_DIGITS(3), .AUTO_RELOAD(1'b0)) u_d1 (
        .clk(clk), .rst(rst_v[1]), .tick(tick_v[1]), .reconfig(reconfig_v[1]),
        .set_value(set_v[1][11:0]), .start(start_v[1]), .pause(pause_v[1]),
        .timer_reset(tres_v[1]), .digits_out(dig1), .running(running_v[1]),
        .expired(expired_v[1]), .done_pulse(pulse_v[1]), .zero(zero_v[1]));

    bcd_countdown_timer #(.NUM_DIGITS(2), .AUTO_RELOAD(1'b1)) u_d2 (
        .clk(clk), .rst(rst_v[2]), .tick(tick_v[2]), .reconfig(reconfig_v[2]),
        .set_value(set_v[2][7:0]), .start(start_v[2]), .pause(pause_v[2]),
        .timer_reset(tres_v[2]), .digits_out(dig2), .running(running_v[2]),
        .expired(expired_v[2]), .done_pulse(pulse_v[2]), .zero(zero_v[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // The model counts in plain decimal; BCD only appears when comparing.
    function automatic m_t step(input m_t m, input int k);
        m_t n;
        int v, p, d;
        n = m;
        n.pulse = 1'b0;
        if (rst_v[k]) begin
            n.cnt = 0; n.rld = 0; n.st = ST_IDLE;
        end else if (reconfig_v[k]) begin
            v = 0; p = 1;
            for (int i = 0; i < nd[k]; i++) begin
                d = int'((set_v[k] >> (4*i)) & 32'hF);
                if (d > 9) d = 9;
                v += d * p;
                p *= 10;
            end
            n.cnt = v; n.rld = v; n.st = ST_IDLE;
        end else if (tres_v[k]) begin
            n.cnt = m.rld; n.st = ST_IDLE;
        end else if (m.st == ST_IDLE) begin
            if (start_v[k] && m.cnt != 0) n.st = ST_RUN;
        end else if (m.st == ST_RUN) begin
            if (pause_v[k]) n.st = ST_PAUSED;
            else if (tick_v[k]) begin
                if (m.cnt == 1) begin
                    n.pulse = 1'b1;
                    if (ar[k] && m.rld != 0) n.cnt = m.rld;
                    else begin n.cnt = 0; n.st = ST_EXP; end
                end else begin
                    n.cnt = m.cnt - 1;
                end
            end
        end else if (m.st == ST_PAUSED) begin
            if (start_v[k] && !pause_v[k]) n.st = ST_RUN;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) mdl[k] <= step(mdl[k], k);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                logic [31:0] dig;
                dig = (k == 0) ? {24'h0, dig0} : (k == 1) ? {20'h0, dig1} : {24'h0, dig2};
                check($sformatf("d%0d_digits", k), dig, to_bcd(mdl[k].cnt, nd[k]));
                check($sformatf("d%0d_running", k), 32'(running_v[k]), 32'(mdl[k].st == ST_RUN));
                check($sformatf("d%0d_expired", k), 32'(expired_v[k]), 32'(mdl[k].st == ST_EXP));
                check($sformatf("d%0d_done_pulse", k), 32'(pulse_v[k]), 32'(mdl[k].pulse));
                check($sformatf("d%0d_zero", k), 32'(zero_v[k]), 32'(mdl[k].cnt == 0));
            end
        end
    end

    // One cycle with the given inputs on instance k; returns at the following negedge.
    task automatic drive(input int k, input bit r, input bit rc, input logic [31:0] sv,
                         input bit tr, input bit st, input bit pa, input bit tk);
        rst_v[k] = r; reconfig_v[k] = rc; set_v[k] = sv; tres_v[k] = tr;
        start_v[k] = st; pause_v[k] = pa; tick_v[k] = tk;
        @(negedge clk);
        rst_v[k] = 1'b0; reconfig_v[k] = 1'b0; tres_v[k] = 1'b0;
        start_v[k] = 1'b0; pause_v[k] = 1'b0; tick_v[k] = 1'b0;
    endtask

    task automatic tick_n(input int k, input int n);
        for (int i = 0; i < n; i++) drive(k, 0, 0, set_v[k], 0, 0, 0, 1);
    endtask

    logic [7:0] ar_exp[7];
    int         pulses;

    initial begin
        ar_exp = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03, 8'h02};
        for (int k = 0; k < 3; k++) begin
            rst_v[k] = 1'b1; reconfig_v[k] = 1'b0; tres_v[k] = 1'b0;
            start_v[k] = 1'b0; pause_v[k] = 1'b0; tick_v[k] = 1'b0; set_v[k] = '0;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst_v[k] = 1'b0;
        chk_en = 1'b1;
        check("reset_digits", {24'h0, dig0}, 32'h00);
        check("reset_zero", 32'(zero_v[0]), 32'h1);
        check("reset_running", 32'(running_v[0]), 32'h0);

        // Full 25-second countdown on the 2-digit timer.
        drive(0, 0, 1, 32'h25, 0, 0, 0, 0);
        drive(0, 0, 0, 32'h25, 0, 1, 0, 0);
        tick_n(0, 5);
        check("cd_after5", {24'h0, dig0}, 32'h20);
        tick_n(0, 1);
        check("cd_after6", {24'h0, dig0}, 32'h19);
        tick_n(0, 19);
        check("cd_end_digits", {24'h0, dig0}, 32'h00);
        check("cd_end_pulse", 32'(pulse_v[0]), 32'h1);
        check("cd_end_expired", 32'(expired_v[0]), 32'h1);
        tick_n(0, 3);
        check("cd_hold_digits", {24'h0, dig0}, 32'h00);
        check("cd_hold_pulse", 32'(pulse_v[0]), 32'h0);
        drive(0, 0, 0, 32'h25, 0, 1, 0, 0);
        check("cd_start_in_expired", 32'(expired_v[0]), 32'h1);

        // Borrow across three digits.
        drive(1, 0, 1, 32'h100, 0, 0, 0, 0);
        drive(1, 0, 0, 32'h100, 0, 1, 0, 0);
        tick_n(1, 1);
        check("borrow_digits", {20'h0, dig1}, 32'h099);
        check("borrow_zero", 32'(zero_v[1]), 32'h0);
        drive(1, 0, 0, 32'h100, 0, 0, 1, 0);
        drive(1, 0, 0, 32'h100, 0, 1, 1, 1);
        check("paused_start_and_pause", 32'(running_v[1]), 32'h0);
        drive(1, 0, 0, 32'h100, 0, 1, 0, 0);
        check("paused_resume", 32'(running_v[1]), 32'h1);

        // Pause/resume on the 2-digit timer.
        drive(0, 0, 1, 32'h10, 0, 0, 0, 0);
        drive(0, 0, 0, 32'h10, 0, 1, 0, 0);
        tick_n(0, 3);
        check("pause_pre", {24'h0, dig0}, 32'h07);
        drive(0, 0, 0, 32'h10, 0, 0, 1, 1);
        tick_n(0, 5);
        check("pause_hold", {24'h0, dig0}, 32'h07);
        check("pause_running", 32'(running_v[0]), 32'h0);
        drive(0, 0, 0, 32'h10, 0, 1, 0, 0);
        tick_n(0, 1);
        check("pause_resume", {24'h0, dig0}, 32'h06);

        // Auto-reload sequence.
        drive(2, 0, 1, 32'h03, 0, 0, 0, 0);
        drive(2, 0, 0, 32'h03, 0, 1, 0, 0);
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            tick_n(2, 1);
            check($sformatf("ar_seq%0d", i), {24'h0, dig2}, {24'h0, ar_exp[i]});
            check($sformatf("ar_running%0d", i), 32'(running_v[2]), 32'h1);
            if (pulse_v[2]) pulses++;
        end
        check("ar_pulse_count", 32'(pulses), 32'd2);

        // Clamp and priority.
        drive(0, 0, 1, 32'hAF, 0, 0, 0, 0);
        check("clamp", {24'h0, dig0}, 32'h99);
        drive(0, 0, 0, 32'hAF, 0, 1, 0, 0);
        drive(0, 0, 1, 32'h40, 1, 0, 0, 1);
        check("prio_digits", {24'h0, dig0}, 32'h40);
        check("prio_idle", 32'(running_v[0] | expired_v[0]), 32'h0);
        drive(0, 1, 0, 32'h40, 0, 0, 0, 0);
        drive(0, 0, 0, 32'h40, 0, 1, 0, 0);
        check("start_zero_idle", 32'(running_v[0]), 32'h0);

        // Reset in the middle of a run, with a tick in the same cycle.
        drive(0, 0, 1, 32'h42, 0, 0, 0, 0);
        drive(0, 0, 0, 32'h42, 0, 1, 0, 0);
        check("rst_pre_running", 32'(running_v[0]), 32'h1);
        drive(0, 1, 0, 32'h42, 0, 0, 0, 1);
        check("rst_digits", {24'h0, dig0}, 32'h00);
        check("rst_zero", 32'(zero_v[0]), 32'h1);
        check("rst_pulse", 32'(pulse_v[0]), 32'h0);
        check("rst_running", 32'(running_v[0]), 32'h0);
        drive(0, 0, 0, 32'h42, 1, 0, 0, 0);
        check("rst_reload_cleared", {24'h0, dig0}, 32'h00);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised N-digit BCD countdown timer; the next generation of the team's cascaded two-digit timer.
- Digit count, auto-reload mode and an explicit run/pause/expire state machine are built in, replacing per-digit borrow chaining.
- Sits between the 1 s tick generator and the 7-segment drivers.
- Flags expiry to the prediction/game control FSM.

Parameters:
- NUM_DIGITS, 2, number of BCD digits (1..8); digit 0 is least significant.
- AUTO_RELOAD, 0, 1 = reload the stored set value on expiry and keep running; 0 = stop in EXPIRED.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- tick  in  1  one-cycle decrement strobe (1 s pulse).
- reconfig  in  1  load set_value into the reload register and the counter.
- set_value  in  4*NUM_DIGITS  BCD preset; nibble i is digit i.
- start  in  1  begin or resume counting.
- pause  in  1  hold the count.
- timer_reset  in  1  restore the count from the reload register and go to IDLE.
- digits_out  out  4*NUM_DIGITS  current BCD count; nibble i drives display i.
- running  out  1  high in RUN.
- expired  out  1  high in EXPIRED.
- done_pulse  out  1  one-cycle pulse on each expiry event.
- zero  out  1  count == 0.

Behaviour:
- Single clock domain; everything registered; the only reset is synchronous, active-high `rst`.
- Reset values:
  - count = 0, reload register = 0, state = IDLE.
  - running = 0, expired = 0, done_pulse = 0, zero = 1.
- States: IDLE, RUN, PAUSED, EXPIRED.
- Per-cycle priority: rst > reconfig > timer_reset > start/pause > tick.
- reconfig (any state):
  - Each nibble of set_value is clamped to 9 when greater than 9.
  - The clamped value is written to both the reload register and count.
  - State becomes IDLE and done_pulse = 0.
- timer_reset (any state): count <= reload register; state becomes IDLE.
- IDLE:
  - start with count != 0 goes to RUN.
  - start with count == 0 is ignored (stays IDLE, no pulse).
  - tick is ignored.
- RUN:
  - pause goes to PAUSED; a tick in that same cycle is ignored.
  - Otherwise tick decrements the count by 1 as a BCD number.
  - Digit 0 decrements; any digit at 0 that must borrow wraps to 9 and borrows from the next digit.
- Expiry: tick in RUN with count == 1:
  - AUTO_RELOAD = 0: count <= 0, state <= EXPIRED, done_pulse <= 1.
  - AUTO_RELOAD = 1: count <= reload register, state stays RUN, done_pulse <= 1.
  - AUTO_RELOAD = 1 with a reload register of 0: count <= 0 and go to EXPIRED.
- PAUSED:
  - start returns to RUN.
  - tick is ignored.
  - start and pause asserted together: pause wins.
- EXPIRED: holds count 0. Exit only via reconfig, timer_reset or rst; start is ignored.
- done_pulse:
  - Registered; high for exactly one cycle, the cycle after the expiry tick edge.
  - Never asserted on reconfig, timer_reset or rst.
- Latency: digits_out updates one cycle after tick is sampled (count register drives the output directly).
- Derived outputs:
  - running = (state == RUN); expired = (state == EXPIRED).
  - zero is derived from the count register (combinational or registered, but cycle-aligned with digits_out).
- tick held high for several cycles decrements once per cycle; the tick generator guarantees single-cycle strobes.

Test Plan:
- Reset, then reconfig with set_value = 0x25 (2 digits), start, 25 ticks:
  - digits_out steps 25, 24, …, 20, 19, …, 01, 00.
  - done_pulse is high for one cycle after the 25th tick.
  - expired = 1, running = 0; further ticks leave the count at 00.
- Borrow across digits with NUM_DIGITS = 3, set 0x100, start, one tick:
  - digits_out = 0x099, zero = 0.
- Pause/resume:
  - Set 0x10, start, 3 ticks gives 07.
  - pause, then 5 ticks: count stays 07 and running = 0.
  - start, then 1 tick gives 06.
- AUTO_RELOAD = 1, set 0x03, start, 7 ticks:
  - Count sequence is 02, 01, 03, 02, 01, 03, 02.
  - done_pulse fires twice; running stays 1 throughout.
- Clamp and priority:
  - set_value = 0xAF with reconfig gives 0x99.
  - reconfig with set_value = 0x40 in the same cycle as timer_reset and tick gives 0x40 and IDLE.
  - start with count 0 (after rst) stays IDLE.
- rst mid-run (count 0x42, RUN, tick the same cycle):
  - Next cycle: count 00, IDLE, zero = 1, done_pulse = 0.
  - Reload register cleared: a subsequent timer_reset gives 00.
